// File: rtl/bcd_modn_counter.sv
// Modulo-N up/down BCD counter with synchronous clear/load, cascade carry
// output, and a one-cycle flag for loads that are rejected.
`timescale 1ns/1ps
module bcd_modn_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  cout,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_modn_counter: DIGITS=%0d outside 1..4", DIGITS);
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_modn_counter: MODULUS=%0d outside 2..10^DIGITS", MODULUS);
  end

  logic [W-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;
  logic [W-1:0] inc_val, dec_val;
  logic         load_ok;
  logic         at_max, at_zero;

  assign at_max  = (count_q == MAX_BCD);
  assign at_zero = (count_q == '0);

  // With every digit in 0..9, plain unsigned compare orders BCD values numerically.
  always_comb begin
    load_ok = (load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  always_comb begin
    logic carry;
    logic borrow;
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d = load_val;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (up) count_d = at_max  ? '0      : inc_val;
      else    count_d = at_zero ? MAX_BCD : dec_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign load_err = load_err_q;
  assign cout     = en & ~clr & ~load & (up ? at_max : at_zero);

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Directed bench: mod-60 stage cascaded into a mod-24 stage, plus a
// 3-digit mod-250 instance for the asynchronous reset case.
`timescale 1ns/1ps
module tb_bcd_modn_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, up, clr, load;
  logic [7:0]  load_val, count;
  logic        cout, load_err;

  logic        hr_clr, hr_load;
  logic [7:0]  hr_load_val, hr_count;
  logic        hr_cout, hr_load_err;

  logic        d3_en, d3_clr, d3_load;
  logic [11:0] d3_load_val, d3_count;
  logic        d3_cout, d3_load_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_modn_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .cout(cout), .load_err(load_err));

  bcd_modn_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk(clk), .rst(rst), .en(cout), .up(up), .clr(hr_clr), .load(hr_load),
    .load_val(hr_load_val), .count(hr_count), .cout(hr_cout), .load_err(hr_load_err));

  bcd_modn_counter #(.DIGITS(3), .MODULUS(250)) u_d3 (
    .clk(clk), .rst(rst), .en(d3_en), .up(up), .clr(d3_clr), .load(d3_load),
    .load_val(d3_load_val), .count(d3_count), .cout(d3_cout), .load_err(d3_load_err));

  typedef struct packed {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lv;
    logic       exp_cout;
    logic [7:0] exp_count;
    logic       exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 0; up = 0; clr = 0; load = 0; load_val = '0;
    hr_clr = 0; hr_load = 0; hr_load_val = '0;
    d3_en = 0; d3_clr = 0; d3_load = 0; d3_load_val = '0;

    // clr load en up lv cout count err
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h47, 1'b0, 8'h47, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h60, 1'b0, 8'h47, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h47, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h3A, 1'b0, 8'h47, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h48, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h59, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h58, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h59, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h25, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h10, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});

    #12;
    chk("reset_count", 32'(count), 32'h00);
    chk("reset_err",   32'(load_err), 32'h0);
    chk("reset_cout",  32'(cout), 32'h0);

    // Free-run up count from reset release: 00..59 then 00.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      chk("run_count", 32'(count), 32'(((i / 10) << 4) | (i % 10)));
      chk("run_cout",  32'(cout), (i == 59) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    #1;
    chk("run_wrap", 32'(count), 32'h00);

    for (int i = 0; i < vq.size(); i++) begin
      clr = vq[i].clr; load = vq[i].load; en = vq[i].en; up = vq[i].up;
      load_val = vq[i].lv;
      #1;
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vq[i].exp_cout));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vq[i].exp_count));
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vq[i].exp_err));
      @(negedge clk);
    end

    // Cascade 23:59 -> 00:00.
    clr = 0; en = 0; up = 1; load = 1; load_val = 8'h59;
    hr_load = 1; hr_load_val = 8'h23;
    @(posedge clk); #1;
    chk("casc_ld_min", 32'(count), 32'h59);
    chk("casc_ld_hr",  32'(hr_count), 32'h23);
    @(negedge clk);
    load = 0; hr_load = 0; en = 1;
    #1;
    chk("casc_min_cout", 32'(cout), 32'h1);
    chk("casc_hr_cout",  32'(hr_cout), 32'h1);
    @(posedge clk); #1;
    chk("casc_min", 32'(count), 32'h00);
    chk("casc_hr",  32'(hr_count), 32'h00);
    @(negedge clk);
    en = 0;

    // Async reset between edges, with an error flag and a 3-digit count live.
    d3_load = 1; d3_load_val = 12'h123; load = 1; load_val = 8'h60;
    @(posedge clk); #1;
    chk("d3_load", 32'(d3_count), 32'h123);
    chk("bad_load_err", 32'(load_err), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_d3", 32'(d3_count), 32'h000);
    chk("async_err", 32'(load_err), 32'h0);
    @(negedge clk);
    d3_load = 0; load = 0;
    rst = 1'b1; en = 1; up = 0;
    #1;
    chk("post_rst_cout", 32'(cout), 32'h1);
    @(posedge clk); #1;
    chk("post_rst_count", 32'(count), 32'h59);
    chk("post_rst_d3", 32'(d3_count), 32'h000);
    @(negedge clk);
    en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
